// File: rtl/rtc_bus_pkg.sv
// Shared constants, state encoding and timer sizing for the RTC bus-cycle generator.
package rtc_bus_pkg;

    localparam logic [7:0] ADDR_CTRL  = 8'h02;
    localparam logic [7:0] ADDR_SEC   = 8'h21;
    localparam logic [7:0] ADDR_MIN   = 8'h22;
    localparam logic [7:0] ADDR_HOUR  = 8'h23;
    localparam logic [7:0] ADDR_DAY   = 8'h24;
    localparam logic [7:0] ADDR_MONTH = 8'h25;
    localparam logic [7:0] ADDR_YEAR  = 8'h26;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A_SET,
        ST_A_STB,
        ST_A_HLD,
        ST_D_SET,
        ST_D_STB,
        ST_D_HLD,
        ST_DONE
    } state_t;

    // Wide enough to hold the longest phase length.
    function automatic int phase_cnt_w(input int s, input int p, input int h);
        int m;
        m = s;
        if (p > m) m = p;
        if (h > m) m = h;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rtc_bus_ctrl_phase_timer.sv
// Loadable down-counter; expired is high once the count has reached zero.
module phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= value;
        else if (count != '0)
            count <= count - W'(1);
    end

    assign expired = (count == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Bus-cycle generator for the RTC chip's multiplexed address/data bus: turns
// level-held init/write/read requests into an address strobe then a data strobe.
module rtc_bus_ctrl
    import rtc_bus_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enini,
    input  logic       enwrite,
    input  logic       enread,
    input  logic       ensec,
    input  logic       enmin,
    input  logic       enhour,
    input  logic       enday,
    input  logic       enmonth,
    input  logic       enyear,
    input  logic [7:0] wdata,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       ad_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       busy,
    output logic       done,
    output logic       sel_err
);

    localparam int CW = phase_cnt_w(T_SETUP, T_PULSE, T_HOLD);
    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);

    state_t state, nstate;
    logic ini_q, wr_q, rd_q, primed;
    logic ini_edge, wr_edge, rd_edge;
    logic [5:0] sel;
    logic [7:0] sel_addr, start_addr, start_data, addr_q, data_q, addr_n, data_n;
    logic start, bad_sel, start_rd, is_rd, rd_n_v;
    logic timer_load, expired;
    logic [CW-1:0] load_val;
    logic a_ph, d_ph;

    // primed blocks a level that was already high at reset release from looking like an edge.
    assign ini_edge = primed & enini   & ~ini_q;
    assign wr_edge  = primed & enwrite & ~wr_q;
    assign rd_edge  = primed & enread  & ~rd_q;
    assign sel      = {enyear, enmonth, enday, enhour, enmin, ensec};

    always_comb begin
        sel_addr = 8'h00;
        case (sel)
            6'b000001: sel_addr = ADDR_SEC;
            6'b000010: sel_addr = ADDR_MIN;
            6'b000100: sel_addr = ADDR_HOUR;
            6'b001000: sel_addr = ADDR_DAY;
            6'b010000: sel_addr = ADDR_MONTH;
            6'b100000: sel_addr = ADDR_YEAR;
            default:   sel_addr = 8'h00;
        endcase
    end

    always_comb begin
        start      = 1'b0;
        bad_sel    = 1'b0;
        start_rd   = 1'b0;
        start_addr = sel_addr;
        start_data = wdata;
        if (state == ST_IDLE) begin
            if (ini_edge) begin
                start      = 1'b1;
                start_addr = ADDR_CTRL;
                start_data = 8'h00;
            end else if (wr_edge) begin
                start   = $onehot(sel);
                bad_sel = ~$onehot(sel);
            end else if (rd_edge) begin
                start    = $onehot(sel);
                start_rd = 1'b1;
                bad_sel  = ~$onehot(sel);
            end
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE:  if (start)   nstate = ST_A_SET;
            ST_A_SET: if (expired) nstate = ST_A_STB;
            ST_A_STB: if (expired) nstate = ST_A_HLD;
            ST_A_HLD: if (expired) nstate = ST_D_SET;
            ST_D_SET: if (expired) nstate = ST_D_STB;
            ST_D_STB: if (expired) nstate = ST_D_HLD;
            ST_D_HLD: if (expired) nstate = ST_DONE;
            default:               nstate = ST_IDLE;
        endcase
    end

    always_comb begin
        load_val = '0;
        case (nstate)
            ST_A_SET, ST_D_SET: load_val = LD_SETUP;
            ST_A_STB, ST_D_STB: load_val = LD_PULSE;
            ST_A_HLD, ST_D_HLD: load_val = LD_HOLD;
            default:            load_val = '0;
        endcase
    end

    assign timer_load = (nstate != state);

    phase_timer #(.W(CW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .value   (load_val),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= nstate;
    end

    // Outputs are decoded from the next state so they line up with the state register.
    assign addr_n = start ? start_addr : addr_q;
    assign data_n = start ? start_data : data_q;
    assign rd_n_v = start ? start_rd   : is_rd;
    assign a_ph   = (nstate == ST_A_SET) || (nstate == ST_A_STB) || (nstate == ST_A_HLD);
    assign d_ph   = (nstate == ST_D_SET) || (nstate == ST_D_STB) || (nstate == ST_D_HLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ini_q       <= 1'b0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            primed      <= 1'b0;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            is_rd       <= 1'b0;
            ad_out      <= 8'h00;
            ad_oe       <= 1'b0;
            cs_n        <= 1'b1;
            ad_n        <= 1'b1;
            wr_n        <= 1'b1;
            rd_n        <= 1'b1;
            rdata       <= 8'h00;
            rdata_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            ini_q       <= enini;
            wr_q        <= enwrite;
            rd_q        <= enread;
            primed      <= 1'b1;
            addr_q      <= addr_n;
            data_q      <= data_n;
            is_rd       <= rd_n_v;
            cs_n        <= ~(a_ph | d_ph);
            ad_n        <= ~a_ph;
            ad_oe       <= a_ph | (d_ph & ~rd_n_v);
            ad_out      <= a_ph ? addr_n : ((d_ph & ~rd_n_v) ? data_n : 8'h00);
            wr_n        <= ~((nstate == ST_A_STB) | ((nstate == ST_D_STB) & ~rd_n_v));
            rd_n        <= ~((nstate == ST_D_STB) & rd_n_v);
            busy        <= (nstate != ST_IDLE);
            done        <= (nstate == ST_DONE);
            sel_err     <= bad_sel;
            rdata_valid <= (state == ST_D_STB) & expired & is_rd;
            if ((state == ST_D_STB) && expired && is_rd)
                rdata <= ad_in;
        end
    end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Bench for rtc_bus_ctrl: offset-based transaction model compared every cycle,
// directed scenarios with literal expectations, then randomized request traffic.
module tb_rtc_bus_ctrl;

  localparam int S = 2;
  localparam int P = 4;
  localparam int H = 2;
  localparam int A_LEN = S + P + H;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic enini = 0, enwrite = 0, enread = 0;
  logic ensec = 0, enmin = 0, enhour = 0, enday = 0, enmonth = 0, enyear = 0;
  logic [7:0] wdata = 8'h00, ad_in = 8'h00;
  logic [7:0] ad_out, rdata;
  logic ad_oe, cs_n, ad_n, wr_n, rd_n, rdata_valid, busy, done, sel_err;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  bit chk_en = 0;
  bit rand_adin = 1;
  logic [7:0] exp_q[$];

  rtc_bus_ctrl #(.T_SETUP(S), .T_PULSE(P), .T_HOLD(H)) dut (
    .clk(clk), .reset(reset),
    .enini(enini), .enwrite(enwrite), .enread(enread),
    .ensec(ensec), .enmin(enmin), .enhour(enhour),
    .enday(enday), .enmonth(enmonth), .enyear(enyear),
    .wdata(wdata), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .ad_n(ad_n),
    .wr_n(wr_n), .rd_n(rd_n), .rdata(rdata), .rdata_valid(rdata_valid),
    .busy(busy), .done(done), .sel_err(sel_err)
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // kn = offset of the current cycle from the accepting edge cycle, -1 when idle.
  int kn = -1;
  bit first = 1;
  logic p_ini = 0, p_wr = 0, p_rd = 0;
  logic [7:0] t_addr = 0, t_data = 0;
  bit t_rd = 0;
  logic [5:0] m_sel;
  int m_idx;
  bit m_wr_e, m_rd_e;
  logic [7:0] e_ad_out = 0, e_rdata = 0;
  logic e_ad_oe = 0, e_cs_n = 1, e_ad_n = 1, e_wr_n = 1, e_rd_n = 1;
  logic e_rv = 0, e_busy = 0, e_done = 0, e_sel_err = 0;

  task automatic set_exp(input int k);
    bit a_ph, d_ph, a_stb, d_stb;
    a_ph  = (k >= 1) && (k <= A_LEN);
    d_ph  = (k > A_LEN) && (k <= 2 * A_LEN);
    a_stb = (k > S) && (k <= S + P);
    d_stb = (k > A_LEN + S) && (k <= A_LEN + S + P);
    e_cs_n   = !(a_ph || d_ph);
    e_ad_n   = !a_ph;
    e_ad_oe  = a_ph || (d_ph && !t_rd);
    e_ad_out = a_ph ? t_addr : ((d_ph && !t_rd) ? t_data : 8'h00);
    e_wr_n   = !(a_stb || (d_stb && !t_rd));
    e_rd_n   = !(d_stb && t_rd);
    e_busy   = (k >= 1);
    e_done   = (k == 2 * A_LEN + 1);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      kn = -1;
      first = 1;
      p_ini = 0; p_wr = 0; p_rd = 0;
      e_rdata = 0; e_rv = 0; e_sel_err = 0;
      exp_q.delete();
      set_exp(-1);
    end else begin
      e_rv = 0;
      e_sel_err = 0;
      if (kn >= 0 && t_rd && kn == A_LEN + S + P) begin
        e_rdata = ad_in;
        e_rv = 1;
        exp_q.push_back(ad_in);
      end
      if (kn >= 0) begin
        kn = (kn == 2 * A_LEN + 1) ? -1 : kn + 1;
      end else if (!first) begin
        m_sel = {enyear, enmonth, enday, enhour, enmin, ensec};
        m_wr_e = enwrite && !p_wr;
        m_rd_e = enread && !p_rd;
        if (enini && !p_ini) begin
          t_addr = 8'h02; t_data = 8'h00; t_rd = 0; kn = 1;
        end else if (m_wr_e || m_rd_e) begin
          if ($countones(m_sel) == 1) begin
            m_idx = 0;
            for (int i = 0; i < 6; i++) if (m_sel[i]) m_idx = i;
            t_addr = 8'h21 + 8'(m_idx);
            t_data = wdata;
            t_rd = !m_wr_e;
            kn = 1;
          end else begin
            e_sel_err = 1;
          end
        end
      end
      first = 0;
      p_ini = enini; p_wr = enwrite; p_rd = enread;
      set_exp(kn);
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk1("cs_n", cs_n, e_cs_n);
      chk1("ad_n", ad_n, e_ad_n);
      chk1("ad_oe", ad_oe, e_ad_oe);
      chk8("ad_out", ad_out, e_ad_out);
      chk1("wr_n", wr_n, e_wr_n);
      chk1("rd_n", rd_n, e_rd_n);
      chk1("busy", busy, e_busy);
      chk1("done", done, e_done);
      chk1("sel_err", sel_err, e_sel_err);
      chk1("rdata_valid", rdata_valid, e_rv);
      chk8("rdata", rdata, e_rdata);
      chk1("strobe_overlap", wr_n | rd_n, 1'b1);
      if (done) done_cnt++;
      if (rdata_valid) begin
        if (exp_q.size() == 0) chk1("rdata_unexpected", rdata_valid, 1'b0);
        else chk8("rdata_queue", rdata, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    if (rand_adin) ad_in = 8'($urandom_range(0, 255));
  endtask

  task automatic set_sel(input logic [5:0] v);
    {enyear, enmonth, enday, enhour, enmin, ensec} = v;
  endtask

  task automatic clear_in();
    enini = 0; enwrite = 0; enread = 0;
    set_sel(6'b0);
    repeat (3) step();
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int dc0;
  int r;

  initial begin : watchdog
    #1000000;
    n_fail++;
    $display("FAIL watchdog: time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1;
    step();
    chk1("rst_cs_n", cs_n, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk8("rst_ad_out", ad_out, 8'h00);
    chk8("rst_rdata", rdata, 8'h00);

    // write seconds
    ensec = 1; wdata = 8'h45; enwrite = 1;
    for (int k = 1; k <= 18; k++) begin
      step();
      if (k == 3) begin chk8("ws_addr", ad_out, 8'h21); chk1("ws_a_wr", wr_n, 1'b0); end
      if (k == 7) chk1("ws_a_wr_end", wr_n, 1'b1);
      if (k == 11) begin chk8("ws_data", ad_out, 8'h45); chk1("ws_d_wr", wr_n, 1'b0); chk1("ws_ad_n", ad_n, 1'b1); end
      if (k == 17) chk1("ws_done", done, 1'b1);
      if (k == 18) chk1("ws_idle", busy, 1'b0);
    end
    clear_in();

    // read minutes
    rand_adin = 0; ad_in = 8'h30;
    enmin = 1; enread = 1;
    for (int k = 1; k <= 18; k++) begin
      step();
      if (k == 3) chk8("rm_addr", ad_out, 8'h22);
      if (k == 11) begin chk1("rm_rd", rd_n, 1'b0); chk1("rm_wr", wr_n, 1'b1); chk1("rm_oe", ad_oe, 1'b0); end
      if (k == 15) begin chk1("rm_valid", rdata_valid, 1'b1); chk8("rm_rdata", rdata, 8'h30); end
      if (k == 16) chk1("rm_valid_pulse", rdata_valid, 1'b0);
    end
    rand_adin = 1;
    clear_in();

    // init wins over a simultaneous write, written once
    dc0 = done_cnt;
    ensec = 1; wdata = 8'hAA; enini = 1; enwrite = 1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 3) chk8("ini_addr", ad_out, 8'h02);
      if (k == 11) begin chk8("ini_data", ad_out, 8'h00); chk1("ini_wr", wr_n, 1'b0); end
    end
    chk_int("ini_once", done_cnt - dc0, 1);
    clear_in();

    // bad select
    ensec = 1; enmin = 1; enwrite = 1;
    step();
    chk1("bs_err", sel_err, 1'b1);
    chk1("bs_cs_n", cs_n, 1'b1);
    chk1("bs_busy", busy, 1'b0);
    step();
    chk1("bs_err_pulse", sel_err, 1'b0);
    chk1("bs_busy2", busy, 1'b0);
    clear_in();

    // retrigger while busy; held enwrite must not restart
    dc0 = done_cnt;
    enhour = 1; wdata = 8'h12; enwrite = 1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 5) enread = 1;
    end
    chk_int("rt_one_done", done_cnt - dc0, 1);
    chk1("rt_idle", busy, 1'b0);
    clear_in();

    // reset in the middle of the data strobe
    enday = 1; wdata = 8'h5A; enwrite = 1;
    repeat (11) step();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk1("rm_wr_n_async", wr_n, 1'b1);
    chk1("rm_cs_n_async", cs_n, 1'b1);
    chk1("rm_oe_async", ad_oe, 1'b0);
    chk1("rm_busy_async", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    dc0 = done_cnt;
    repeat (25) step();
    chk_int("rm_no_done", done_cnt - dc0, 0);
    chk1("rm_no_restart", busy, 1'b0);
    clear_in();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) enwrite = ~enwrite;
      if ($urandom_range(0, 7) == 0) enread = ~enread;
      if ($urandom_range(0, 40) == 0) enini = ~enini;
      if ($urandom_range(0, 9) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 8) set_sel(6'(1 << $urandom_range(0, 5)));
        else if (r == 8) set_sel(6'b0);
        else set_sel(6'($urandom_range(0, 63)));
      end
      if ($urandom_range(0, 3) == 0) wdata = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1500) == 0) pulse_reset();
      step();
    end
    clear_in();
    repeat (25) step();
    chk_int("end_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
